// File: rtl/div_defs.sv
// Shared constants and FSM encoding for the sequential radix-2 divider.
package div_defs;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: absolute value on the way in,
// quotient/remainder sign restoration on the way out.
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/div_seq_responder.sv
// Multi-cycle restoring divider answering the EX-stage divide handshake.
// Optional build macro: DIV_EARLY_OUT_EN (skip iterations when |a| < |b|).
module div_seq_responder
  import div_defs::*;
#(
  parameter int DATA_W = div_defs::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);

  div_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic              sgn_q, sgn_d, a_neg_q, a_neg_d, sdiff_q, sdiff_d;
  logic [DATA_W-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] abs_a, abs_b, raw_q, raw_r, fix_q, fix_r;
  logic              fix_en, cur_sgn, cur_a_neg, cur_sdiff, load_res;

  // Live operand flags are used only while accepting; afterwards the latched copies.
  assign cur_sgn   = (state_q == DIV_FREE) ? signed_div : sgn_q;
  assign cur_a_neg = (state_q == DIV_FREE) ? a[DATA_W-1] : a_neg_q;
  assign cur_sdiff = (state_q == DIV_FREE) ? (a[DATA_W-1] ^ b[DATA_W-1]) : sdiff_q;

  div_sign_fix #(.W(DATA_W)) u_abs_a (.val(a), .neg(signed_div & a[DATA_W-1]), .res(abs_a));
  div_sign_fix #(.W(DATA_W)) u_abs_b (.val(b), .neg(signed_div & b[DATA_W-1]), .res(abs_b));
  div_sign_fix #(.W(DATA_W)) u_fix_q (.val(raw_q), .neg(fix_en & cur_sgn & cur_sdiff), .res(fix_q));
  div_sign_fix #(.W(DATA_W)) u_fix_r (.val(raw_r), .neg(fix_en & cur_sgn & cur_a_neg), .res(fix_r));

  // One restoring step: the extra top bit makes the compare a plain sign test.
  logic [DATA_W+1:0] shifted, diff;
  logic              step_ge;
  logic [DATA_W:0]   step_rem;
  logic [DATA_W-1:0] step_quo;

  always_comb begin
    shifted  = {rem_q, dvd_q[DATA_W-1]};
    diff     = shifted - {2'b00, dvs_q};
    step_ge  = ~diff[DATA_W+1];
    step_rem = step_ge ? diff[DATA_W:0] : shifted[DATA_W:0];
    step_quo = {dvd_q[DATA_W-2:0], step_ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    a_neg_d  = a_neg_q;
    sdiff_d  = sdiff_q;
    quo_d    = quo_q;
    rmd_d    = rmd_q;
    done_d   = 1'b0;
    load_res = 1'b0;
    raw_q    = '0;
    raw_r    = '0;
    fix_en   = 1'b0;
    case (state_q)
      DIV_FREE: begin
        if (start && !annul) begin
          rem_d   = '0;
          dvd_d   = abs_a;
          dvs_d   = abs_b;
          sgn_d   = signed_div;
          a_neg_d = a[DATA_W-1];
          sdiff_d = a[DATA_W-1] ^ b[DATA_W-1];
          cnt_d   = '0;
          if (b == '0) begin
            state_d = DIV_BY_ZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_a < abs_b) begin
            state_d  = DIV_END;
            load_res = 1'b1;
            raw_r    = abs_a;
            fix_en   = 1'b1;
          end
`endif
          else begin
            state_d = DIV_ON;
          end
        end
      end
      DIV_ON: begin
        if (annul) begin
          state_d = DIV_FREE;
        end else begin
          rem_d = step_rem;
          dvd_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_d  = DIV_END;
            load_res = 1'b1;
            raw_q    = step_quo;
            raw_r    = step_rem[DATA_W-1:0];
            fix_en   = 1'b1;
          end
        end
      end
      DIV_BY_ZERO: begin
        if (annul) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          load_res = 1'b1;
        end
      end
      DIV_END: state_d = DIV_FREE;
      default: state_d = DIV_FREE;
    endcase
    if (load_res) begin
      quo_d  = fix_q;
      rmd_d  = fix_r;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      sdiff_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      a_neg_q <= a_neg_d;
      sdiff_q <= sdiff_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      done_q  <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign done      = done_q;
  assign busy      = (state_q != DIV_FREE);

endmodule

// File: tb/tb_div_seq_responder.sv
// Randomized scoreboard bench for div_seq_responder against an arithmetic model.
module tb_div_seq_responder;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b, quotient, remainder;
  logic        done, busy;

  div_seq_responder dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start), .signed_div(signed_div),
    .annul(annul), .quotient(quotient), .remainder(remainder), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          dc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic; truncating division matches DIV/DIVU semantics.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                 input int acc);
    exp_t   e;
    longint sx, sy, q, r, ax, ay;
    int     lat;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    ax = (sx < 0) ? -sx : sx;
    ay = (sy < 0) ? -sy : sy;
    if (y == 0) begin
      q = 0; r = 0; lat = 1;
    end else begin
      q = sx / sy; r = sx % sy; lat = 32;
`ifdef DIV_EARLY_OUT_EN
      if (ax < ay) lat = 0;
`endif
    end
    e.q  = q[31:0];
    e.r  = r[31:0];
    e.dc = acc + lat;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("done_cycle", cyc, e.dc);
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  int acc;

  // Called at a negedge; if done is showing, the DUT needs one cycle to return to FREE.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x; b = y; signed_div = s; start = 1'b1;
    acc = done ? cyc + 2 : cyc + 1;
    sb.push_back(model(x, y, s, acc));
  endtask

  task automatic wait_done(input logic hold);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (cyc >= acc) chk("busy_during_op", busy, 1'b1);
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      if (sb.size() != 0) void'(sb.pop_back());
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic s);
    issue(x, y, s);
    wait_done(1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    op(32'd7, 32'd2, 1'b0);
    op(32'hFFFF_FFF9, 32'd2, 1'b1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    op(32'd5, 32'd0, 1'b0);
    op(32'd5, 32'd0, 1'b1);
    op(32'd3, 32'hFFFF_FFF6, 1'b1);

    // Annul at T+10 aborts silently and leaves outputs alone.
    issue(32'd1234, 32'd5, 1'b0);
    repeat (10) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("annul_busy", busy, 1'b0);
    chk("annul_done", done, 1'b0);
    chk("annul_quotient", quotient, last_q);
    chk("annul_remainder", remainder, last_r);
    annul = 1'b0;
    @(negedge clk);
    op(32'd100, 32'd7, 1'b0);

    // Annul in FREE masks start.
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3;
    repeat (3) begin
      @(negedge clk);
      chk("annul_free_busy", busy, 1'b0);
    end
    start = 1'b0; annul = 1'b0;
    @(negedge clk);

    // Reset mid-operation, then back-to-back with start held throughout.
    issue(32'd999, 32'd4, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    last_q = '0; last_r = '0;
    rst = 1'b0;
    @(negedge clk);
    issue(32'd50, 32'd6, 1'b0);          wait_done(1'b1);
    issue(32'hFFFF_FF00, 32'd7, 1'b1);   wait_done(1'b1);
    issue(32'd17, 32'd0, 1'b0);          wait_done(1'b1);
    issue(32'd1, 32'd3, 1'b1);           wait_done(1'b0);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] x, y;
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = $urandom_range(1, 16);
        2: x = $urandom_range(0, 100);
        3: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      op(x, y, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq_responder.md
Name: div_seq_responder

Overview:
- Multi-cycle 32-bit radix-2 restoring divider; the responder on the EX-stage divide handshake.
- The ALU drives start/signed_div/operands and holds start high until done; this block computes and returns quotient/remainder for the HI/LO write.
- Supports signed (DIV) and unsigned (DIVU) division, a pipeline-flush annul, and a fixed divide-by-zero result.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
a  in  DATA_W  dividend, sampled only on accepted start
b  in  DATA_W  divisor, sampled only on accepted start
start  in  1  divide request, level; accepted only in DIV_FREE
signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
annul  in  1  flush/exception; aborts any operation in flight
quotient  out  DATA_W  registered result (LO)
remainder  out  DATA_W  registered result (HI)
done  out  1  registered one-cycle pulse; results valid this cycle
busy  out  1  high in any state except DIV_FREE

Behaviour:
- Reset (rst=1 at edge): state=DIV_FREE, quotient=0, remainder=0, done=0, busy=0, iteration counter=0. Reset mid-operation abandons work silently; no done.
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
- DIV_FREE, start=1 and annul=0 at cycle T:
  - Latch |a| and |b| (absolute values when signed_div=1; raw values otherwise), the sign of a, sign(a)^sign(b), and signed_div.
  - Next state is DIV_BY_ZERO if b==0, otherwise DIV_ON. Counter=0.
- DIV_ON: one restoring step per cycle.
  - Shift {rem, dividend} left 1 and subtract the divisor with a 33-bit compare.
  - If the result is non-negative, commit it and shift in quotient bit 1; otherwise shift in 0.
  - After DATA_W steps (cycles T+1..T+32) go to DIV_END.
- DIV_BY_ZERO: one cycle, then DIV_END with raw results q=0, r=0.
- DIV_END (cycle T+33 normal, T+2 div-by-zero):
  - done=1; quotient/remainder registers updated this cycle.
  - Signed correction: quotient negated when the operand signs differ; remainder takes the dividend's sign. No sign correction is applied to the divide-by-zero result.
  - Next state DIV_FREE.
- Result hold: quotient/remainder stay stable after done until the next DIV_END or reset.
- start while busy: ignored; operand changes mid-operation are ignored.
- start still high in the cycle after done (state DIV_FREE): accepted as a new request. The ALU must drop start on seeing done.
- annul=1:
  - In any non-FREE state: next state DIV_FREE, done stays 0, outputs keep their prior values.
  - In DIV_FREE: annul overrides start, so nothing is accepted.
  - annul in DIV_END: done is already asserted that cycle and is not retracted.
- Overflow case (signed 0x80000000 / 0xFFFFFFFF): q=0x80000000, r=0 (two's-complement wrap), no trap.
- Width rules: partial remainder DATA_W+1 bits; quotient and remainder truncated to DATA_W.

Optional Feature:
Macro DIV_EARLY_OUT_EN.
- Defined: on accept in DIV_FREE, if b≠0 and |a|<|b|, go directly to DIV_END with raw q=0, r=|a|. Signed correction then yields remainder=a, so done arrives at T+1.
- Not defined: every non-zero divisor takes the full DATA_W iterations (done at T+33).

Decomposition:
- Shared package div_defs:
  - DATA_W default.
  - State encodings DIV_FREE/DIV_BY_ZERO/DIV_ON/DIV_END (2-bit).
  - Iteration-count width constant.
- One natural combinational sub-module div_sign_fix: absolute-value input conditioning plus quotient/remainder sign correction, reused on both input and output sides.
- The FSM, counter and datapath stay in the top module.

Test Plan:
- Unsigned 7/2, start at T held until done → done only at T+33; q=3, r=1; busy high T+1..T+33.
- Signed -7 (0xFFFFFFF9) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0. Same operands unsigned → q=0, r=0x80000000.
- 5/0 (either signedness) → done at T+2; q=0, r=0.
- Annul at T+10 mid-DIV_ON → no done, busy=0 at T+11, outputs unchanged. Then unsigned 100/7 → q=14, r=2 at done.
- rst asserted at T+20 during an operation → all outputs 0 next cycle, no done. start held continuously afterward → back-to-back accepts, exactly one done per operation.
- With DIV_EARLY_OUT_EN, signed 3/-10 → done at T+1, q=0, r=3. Without the macro → done at T+33, same values.
